// File: rtl/nms_window_ctrl_pkg.sv
// Shared definitions for the NMS window sequencer: direction codes, window geometry, FSM states.
// Window geometry is unaffected by NMS_WIN_BORDER_PAD_EN; only the column range read per row changes.
package nms_window_ctrl_pkg;

  localparam logic [7:0] DIR_H    = 8'd1;
  localparam logic [7:0] DIR_D135 = 8'd2;
  localparam logic [7:0] DIR_V    = 8'd3;
  localparam logic [7:0] DIR_D45  = 8'd4;

  localparam int PIX_W     = 8;
  localparam int ROW_W     = 3 * PIX_W;
  localparam int WIN_W     = 3 * ROW_W;
  localparam int WIN_C_LSB = 32;
  localparam int NMS_LINES = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } nms_state_e;

endpackage

// File: rtl/nms_window_ctrl_line_buf.sv
// One line of {mag,dir} pixel pairs with a write port and a registered 3-column read.
// With NMS_WIN_BORDER_PAD_EN, rd_ptr names the centre column and off-line neighbours read as zero.
module nms_window_ctrl_line_buf
  import nms_window_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  parameter int PTR_W     = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_ptr,
  input  logic [2*PIX_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [PTR_W-1:0]   rd_ptr,
  output logic [ROW_W-1:0]   rd_mag,
  output logic [ROW_W-1:0]   rd_dir
);

  logic [2*PIX_W-1:0] mem_q [IMG_WIDTH];
  logic [2*PIX_W-1:0] pix_l, pix_c, pix_r;
  logic [ROW_W-1:0]   rd_mag_d, rd_mag_q, rd_dir_d, rd_dir_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= wr_data;
  end

`ifdef NMS_WIN_BORDER_PAD_EN
  always_comb begin
    pix_c = mem_q[rd_ptr];
    pix_l = (rd_ptr == '0) ? '0 : mem_q[rd_ptr - PTR_W'(1)];
    pix_r = (rd_ptr == PTR_W'(IMG_WIDTH-1)) ? '0 : mem_q[rd_ptr + PTR_W'(1)];
  end
`else
  always_comb begin
    pix_l = mem_q[rd_ptr];
    pix_c = mem_q[rd_ptr + PTR_W'(1)];
    pix_r = mem_q[rd_ptr + PTR_W'(2)];
  end
`endif

  // Left column lands in the most significant byte of each row.
  always_comb begin
    rd_mag_d = rd_mag_q;
    rd_dir_d = rd_dir_q;
    if (rd_en) begin
      rd_mag_d = {pix_l[2*PIX_W-1:PIX_W], pix_c[2*PIX_W-1:PIX_W], pix_r[2*PIX_W-1:PIX_W]};
      rd_dir_d = {pix_l[PIX_W-1:0], pix_c[PIX_W-1:0], pix_r[PIX_W-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_mag_q <= '0;
      rd_dir_q <= '0;
    end else begin
      rd_mag_q <= rd_mag_d;
      rd_dir_q <= rd_dir_d;
    end
  end

  assign rd_mag = rd_mag_q;
  assign rd_dir = rd_dir_q;

endmodule

// File: rtl/nms_window_ctrl.sv
// NMS window sequencer: 4-line rotating buffer, occupancy tracking, row read FSM, intr/ovf.
// NMS_WIN_BORDER_PAD_EN widens each output row to IMG_WIDTH zero-padded windows.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for 3 resident lines; one bubble cycle between rows
// ST_RD   | issuing one 3x3 window read per cycle along the current row
module nms_window_ctrl
  import nms_window_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  parameter int PTR_W     = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       pix_mag,
  input  logic [7:0]       pix_dir,
  input  logic             pix_valid,
  output logic [WIN_W-1:0] mag_data,
  output logic             mag_data_valid,
  output logic [WIN_W-1:0] dir_data,
  output logic             dir_data_valid,
  output logic             intr,
  output logic             ovf
);

  localparam int OCC_W = $clog2(NMS_LINES*IMG_WIDTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(NMS_LINES*IMG_WIDTH);
  localparam logic [OCC_W-1:0] OCC_START = OCC_W'((NMS_LINES-1)*IMG_WIDTH);
  localparam logic [OCC_W-1:0] OCC_LINE  = OCC_W'(IMG_WIDTH);
  localparam logic [PTR_W-1:0] WR_LAST   = PTR_W'(IMG_WIDTH-1);
`ifdef NMS_WIN_BORDER_PAD_EN
  localparam logic [PTR_W-1:0] RD_LAST   = PTR_W'(IMG_WIDTH-1);
`else
  localparam logic [PTR_W-1:0] RD_LAST   = PTR_W'(IMG_WIDTH-3);
`endif

  nms_state_e       state_d, state_q;
  logic [1:0]       wr_sel_d, wr_sel_q, rd_sel_d, rd_sel_q, out_sel_d, out_sel_q;
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [OCC_W-1:0] occ_d, occ_q;
  logic             ovf_d, ovf_q, intr_d, intr_q, valid_d, valid_q;
  logic             full, wr_acc, rd_en, line_done;
  logic [1:0]       row1_sel, row2_sel;
  logic [ROW_W-1:0] buf_mag [NMS_LINES];
  logic [ROW_W-1:0] buf_dir [NMS_LINES];

  assign full   = (occ_q == OCC_FULL);
  assign wr_acc = pix_valid && !full;

  for (genvar i = 0; i < NMS_LINES; i++) begin : g_line
    nms_window_ctrl_line_buf #(
      .IMG_WIDTH (IMG_WIDTH),
      .PTR_W     (PTR_W)
    ) u_line_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_acc && (wr_sel_q == 2'(i))),
      .wr_ptr  (wr_ptr_q),
      .wr_data ({pix_mag, pix_dir}),
      .rd_en   (rd_en),
      .rd_ptr  (rd_ptr_q),
      .rd_mag  (buf_mag[i]),
      .rd_dir  (buf_dir[i])
    );
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    wr_sel_d = wr_sel_q;
    if (wr_acc) begin
      if (wr_ptr_q == WR_LAST) begin
        wr_ptr_d = '0;
        wr_sel_d = wr_sel_q + 2'd1;
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    rd_sel_d  = rd_sel_q;
    out_sel_d = out_sel_q;
    rd_en     = 1'b0;
    line_done = 1'b0;
    case (state_q)
      ST_IDLE: if (occ_q >= OCC_START) state_d = ST_RD;
      ST_RD: begin
        rd_en     = 1'b1;
        out_sel_d = rd_sel_q;
        if (rd_ptr_q == RD_LAST) begin
          rd_ptr_d  = '0;
          rd_sel_d  = rd_sel_q + 2'd1;
          line_done = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A write and a row release in the same cycle net to +1-IMG_WIDTH.
  always_comb begin
    occ_d = occ_q;
    if (wr_acc)    occ_d = occ_d + OCC_W'(1);
    if (line_done) occ_d = occ_d - OCC_LINE;
    ovf_d   = ovf_q | (pix_valid & full);
    intr_d  = line_done;
    valid_d = rd_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_sel_q  <= '0;
      wr_ptr_q  <= '0;
      rd_sel_q  <= '0;
      rd_ptr_q  <= '0;
      out_sel_q <= '0;
      occ_q     <= '0;
      ovf_q     <= 1'b0;
      intr_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_sel_q  <= wr_sel_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_sel_q  <= rd_sel_d;
      rd_ptr_q  <= rd_ptr_d;
      out_sel_q <= out_sel_d;
      occ_q     <= occ_d;
      ovf_q     <= ovf_d;
      intr_q    <= intr_d;
      valid_q   <= valid_d;
    end
  end

  // out_sel_q is the rd_sel of the registered read, so rotation never skews a window.
  assign row1_sel = out_sel_q + 2'd1;
  assign row2_sel = out_sel_q + 2'd2;

  assign mag_data       = {buf_mag[row2_sel], buf_mag[row1_sel], buf_mag[out_sel_q]};
  assign dir_data       = {buf_dir[row2_sel], buf_dir[row1_sel], buf_dir[out_sel_q]};
  assign mag_data_valid = valid_q;
  assign dir_data_valid = valid_q;
  assign intr           = intr_q;
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_nms_window_ctrl.sv
// Bench for nms_window_ctrl at IMG_WIDTH=8: windows scoreboarded against a pixel-stream model.
// Honours NMS_WIN_BORDER_PAD_EN for row length and edge padding.
module tb_nms_window_ctrl;
  import nms_window_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int PW = 3;
`ifdef NMS_WIN_BORDER_PAD_EN
  localparam int WPR  = W;
  localparam int COFF = -1;
  localparam logic [71:0] FIRST_MAG = 72'h00_10_11_00_08_09_00_00_01;
  localparam logic [71:0] FIRST_DIR = 72'h00_01_01_00_01_01_00_01_01;
  localparam logic [7:0]  FIRST_C   = 8'd8;
`else
  localparam int WPR  = W - 2;
  localparam int COFF = 0;
  localparam logic [71:0] FIRST_MAG = 72'h10_11_12_08_09_0A_00_01_02;
  localparam logic [71:0] FIRST_DIR = 72'h01_01_01_01_01_01_01_01_01;
  localparam logic [7:0]  FIRST_C   = 8'd9;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  pix_mag = '0, pix_dir = '0;
  logic        pix_valid = 1'b0;
  logic [71:0] mag_data, dir_data;
  logic        mag_data_valid, dir_data_valid, intr, ovf;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] acc_q[$];
  int          win_cnt = 0;
  int          intr_cnt = 0;
  logic        ovf_exp = 1'b0;
  logic [71:0] first_mag = '0, first_dir = '0;

  nms_window_ctrl #(.IMG_WIDTH(W), .PTR_W(PW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pix_mag        (pix_mag),
    .pix_dir        (pix_dir),
    .pix_valid      (pix_valid),
    .mag_data       (mag_data),
    .mag_data_valid (mag_data_valid),
    .dir_data       (dir_data),
    .dir_data_valid (dir_data_valid),
    .intr           (intr),
    .ovf            (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window n of the stream: row n/WPR uses accepted lines r..r+2, columns from n%WPR.
  function automatic logic [71:0] exp_win(input int n, input bit is_dir);
    logic [71:0] w;
    int r, p;
    w = '0;
    r = n / WPR;
    p = n % WPR;
    for (int j = 0; j < 3; j++) begin
      for (int c = 0; c < 3; c++) begin
        int col;
        int idx;
        logic [7:0] b;
        col = p + c + COFF;
        idx = (r + j) * W + col;
        if (col < 0 || col >= W) b = 8'h00;
        else if (idx >= acc_q.size()) b = 8'hEE;
        else b = is_dir ? acc_q[idx][7:0] : acc_q[idx][15:8];
        w[j*24 + (2-c)*8 +: 8] = b;
      end
    end
    return w;
  endfunction

  function automatic logic [7:0] rand_dir();
    case ($urandom_range(0, 3))
      0:       return DIR_H;
      1:       return DIR_D135;
      2:       return DIR_V;
      default: return DIR_D45;
    endcase
  endfunction

  // One cycle: check outputs at the falling edge, then drive the next pixel.
  task automatic tick(input bit v, input logic [7:0] m, input logic [7:0] d);
    @(negedge clk);
    if (rst_n) begin
      chk("dir_valid_eq", dir_data_valid, mag_data_valid);
      if (mag_data_valid) begin
        chk("mag_win", mag_data, exp_win(win_cnt, 1'b0));
        chk("dir_win", dir_data, exp_win(win_cnt, 1'b1));
        if (win_cnt == 0) begin
          first_mag = mag_data;
          first_dir = dir_data;
        end
        win_cnt++;
      end
      if (intr) intr_cnt++;
      chk("intr_align", intr, mag_data_valid && (win_cnt % WPR == 0));
    end
    pix_valid = v;
    pix_mag   = m;
    pix_dir   = d;
    if (v) begin
      if (acc_q.size() - W * (win_cnt / WPR) < 4 * W) acc_q.push_back({m, d});
      else ovf_exp = 1'b1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    #1;
    chk("rst_mag", mag_data, 72'h0);
    chk("rst_dir", dir_data, 72'h0);
    chk("rst_valid", {dir_data_valid, mag_data_valid}, 72'h0);
    chk("rst_intr", intr, 72'h0);
    chk("rst_ovf", ovf, 72'h0);
    acc_q.delete();
    win_cnt  = 0;
    intr_cnt = 0;
    ovf_exp  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt, budget, run_len, gap;

    apply_reset();

    // Reset in the middle of an active row.
    for (int i = 0; i < 28; i++) tick(1'b1, 8'($urandom), rand_dir());
    chk("pre_rst_seen_windows", win_cnt > 0, 72'h1);
    apply_reset();

    // Ramp: latency, first window contents, one intr per row.
    for (int i = 0; i < 24; i++) tick(1'b1, 8'(i), DIR_H);
    tick(1'b0, 8'h0, 8'h0);
    chk("lat_cycle0", mag_data_valid, 72'h0);
    tick(1'b0, 8'h0, 8'h0);
    chk("lat_cycle1", mag_data_valid, 72'h0);
    tick(1'b0, 8'h0, 8'h0);
    chk("lat_cycle2", mag_data_valid, 72'h1);
    repeat (12) tick(1'b0, 8'h0, 8'h0);
    chk("ramp_first_mag", first_mag, FIRST_MAG);
    chk("ramp_first_dir", first_dir, FIRST_DIR);
    chk("ramp_centre", first_mag[WIN_C_LSB +: 8], FIRST_C);
    chk("ramp_windows", win_cnt, WPR);
    chk("ramp_intr", intr_cnt, 1);

    // Write lands with the end-of-row release; then finish 5 lines.
    apply_reset();
    for (int i = 0; i < 33; i++) tick(1'b1, 8'($urandom), rand_dir());
    tick(1'b0, 8'h0, 8'h0);
    chk("simul_occ", dut.occ_q, 33 - W);
    chk("simul_ovf", ovf, 72'h0);
    for (int i = 0; i < 7; i++) tick(1'b1, 8'($urandom), rand_dir());
    repeat (40) tick(1'b0, 8'h0, 8'h0);
    chk("five_line_intr", intr_cnt, 3);
    chk("five_line_windows", win_cnt, 3 * WPR);

    // Random gaps over 12 lines exercise buffer rotation several times.
    apply_reset();
    cnt = 0;
    while (cnt < 12 * W) begin
      bit v;
      v = ($urandom_range(0, 2) != 0);
      tick(v, 8'($urandom), rand_dir());
      if (v) cnt++;
    end
    repeat (60) tick(1'b0, 8'h0, 8'h0);
    chk("rand_windows", win_cnt, 10 * WPR);
    chk("rand_intr", intr_cnt, 10);
    chk("rand_ovf", ovf, 72'h0);

    // Overflow with reads held off, then back-to-back rows with one bubble.
    apply_reset();
    force dut.state_q = ST_IDLE;
    for (int i = 0; i < 33; i++) tick(1'b1, 8'($urandom), rand_dir());
    tick(1'b0, 8'h0, 8'h0);
    chk("ovf_set", ovf, ovf_exp);
    chk("ovf_set_abs", ovf, 72'h1);
    chk("ovf_occ_hold", dut.occ_q, 4 * W);
    chk("ovf_wr_ptr_hold", {dut.wr_sel_q, dut.wr_ptr_q}, 72'h0);
    chk("ovf_no_reads", win_cnt, 0);
    release dut.state_q;
    budget  = 0;
    run_len = 0;
    gap     = 0;
    while (!mag_data_valid && budget < 20) begin tick(1'b0, 8'h0, 8'h0); budget++; end
    while (mag_data_valid && budget < 40) begin run_len++; tick(1'b0, 8'h0, 8'h0); budget++; end
    while (!mag_data_valid && budget < 60) begin gap++; tick(1'b0, 8'h0, 8'h0); budget++; end
    chk("bubble_budget", budget < 60, 72'h1);
    chk("row_len", run_len, WPR);
    chk("bubble_len", gap, 1);
    repeat (30) tick(1'b0, 8'h0, 8'h0);
    chk("ovf_rows_intr", intr_cnt, 2);
    chk("ovf_rows_windows", win_cnt, 2 * WPR);
    for (int i = 0; i < 3; i++) tick(1'b1, 8'($urandom), rand_dir());
    tick(1'b0, 8'h0, 8'h0);
    chk("ovf_sticky", ovf, 72'h1);
    apply_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
